// File: rtl/skintone_pkg.sv
// Fixed-point and counter constants shared by the skin-tone classifier.
// Pixel means are unsigned 9.9; distances and limits use the same format.
package skintone_pkg;

  localparam int FP_INT_W  = 9;
  localparam int FP_FRAC_W = 9;
  localparam int FP_W      = FP_INT_W + FP_FRAC_W;
  localparam int DIFF_W    = FP_W + 1;
  localparam int COUNT_W   = 20;

  typedef logic [FP_W-1:0]    fp_t;
  typedef logic [COUNT_W-1:0] count_t;

  localparam fp_t    MEAN_DEFAULT_FP = 18'd78848;
  localparam fp_t    THRESH_FP       = 18'd5120;
  localparam count_t COUNT_MAX       = '1;

endpackage

// File: rtl/cr_delay_line.sv
// Fixed-depth shift register carrying a data word and its valid bit; the valid
// bit shifts every cycle so the output lines up with a later-arriving stream.
module cr_delay_line #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;

  always_comb begin
    data_d[0] = in_data;
    vld_d[0]  = in_vld;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data = data_q[DEPTH-1];
  assign out_vld  = vld_q[DEPTH-1];

endmodule

// File: rtl/skin_classifier.sv
// Classifies pixels as skin by |Cr - mean Cr| <= THRESH in 9.9 fixed point.
// Define SKIN_COUNT_EN to build the per-frame skin pixel counter.
module skin_classifier
  import skintone_pkg::*;
#(
  parameter int          CR_DELAY     = 4,
  parameter logic [17:0] THRESH       = THRESH_FP,
  parameter logic [17:0] MEAN_DEFAULT = MEAN_DEFAULT_FP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cr_value,
  input  logic        cr_value_valid,
  input  logic        frame_end,
  input  logic [17:0] mean_cr_result,
  input  logic        mean_cr_result_valid,
  output logic        skin_mask,
  output logic        skin_mask_valid,
  output logic [19:0] skin_count,
  output logic        skin_count_valid,
  output logic        align_error
);

  function automatic fp_t abs_diff(input logic signed [DIFF_W-1:0] d);
    logic signed [DIFF_W-1:0] neg;
    neg = -d;
    return d[DIFF_W-1] ? neg[FP_W-1:0] : d[FP_W-1:0];
  endfunction

  function automatic count_t sat_inc(input count_t c, input logic inc);
    return (inc && (c != COUNT_MAX)) ? c + count_t'(1) : c;
  endfunction

`ifdef SKIN_COUNT_EN
  localparam int DLY_W = 9;
`else
  localparam int DLY_W = 8;
`endif

  logic [DLY_W-1:0] dly_in, dly_out;
  logic [7:0]       cr_dly;
  logic             vld_dly;
  logic             fe_dly;

`ifdef SKIN_COUNT_EN
  assign dly_in = {frame_end, cr_value};
  assign cr_dly = dly_out[7:0];
  assign fe_dly = dly_out[8];
`else
  logic unused_fe;
  assign dly_in    = cr_value;
  assign cr_dly    = dly_out;
  assign fe_dly    = 1'b0;
  assign unused_fe = frame_end ^ fe_dly;
`endif

  cr_delay_line #(
    .DEPTH  (CR_DELAY),
    .DATA_W (DLY_W)
  ) u_cr_delay_line (
    .clk      (clk),
    .rst      (rst),
    .in_data  (dly_in),
    .in_vld   (cr_value_valid),
    .out_data (dly_out),
    .out_vld  (vld_dly)
  );

  fp_t                      mean_eff;
  logic signed [DIFF_W-1:0] diff_p1_d, diff_p1_q;
  logic                     fe_p1_d, fe_p1_q;
  logic                     vld_p1_d, vld_p1_q;
  logic                     align_error_d, align_error_q;
  logic                     skin_mask_d, skin_mask_q;
  logic                     skin_mask_valid_d, skin_mask_valid_q;

  always_comb begin
    mean_eff          = (mean_cr_result == '0) ? MEAN_DEFAULT : mean_cr_result;
    diff_p1_d         = $signed({2'b00, cr_dly, 9'b0}) - $signed({1'b0, mean_eff});
    fe_p1_d           = fe_dly;
    vld_p1_d          = vld_dly & mean_cr_result_valid;
    align_error_d     = align_error_q | (vld_dly ^ mean_cr_result_valid);
    skin_mask_d       = vld_p1_q & (abs_diff(diff_p1_q) <= THRESH);
    skin_mask_valid_d = vld_p1_q;
  end

  // Stage 1 / stage 2 boundary: data registers carry no reset, valids do.
  always_ff @(posedge clk) begin
    diff_p1_q <= diff_p1_d;
    fe_p1_q   <= fe_p1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q          <= 1'b0;
      align_error_q     <= 1'b0;
      skin_mask_q       <= 1'b0;
      skin_mask_valid_q <= 1'b0;
    end else begin
      vld_p1_q          <= vld_p1_d;
      align_error_q     <= align_error_d;
      skin_mask_q       <= skin_mask_d;
      skin_mask_valid_q <= skin_mask_valid_d;
    end
  end

  assign skin_mask       = skin_mask_q;
  assign skin_mask_valid = skin_mask_valid_q;
  assign align_error     = align_error_q;

`ifdef SKIN_COUNT_EN
  count_t frame_cnt_d, frame_cnt_q;
  count_t skin_count_d, skin_count_q;
  logic   skin_count_valid_d, skin_count_valid_q;
  count_t cnt_inc;

  // The frame total includes the frame_end pixel itself, hence the look-ahead on skin_mask_d.
  always_comb begin
    cnt_inc            = sat_inc(frame_cnt_q, skin_mask_d);
    frame_cnt_d        = frame_cnt_q;
    skin_count_d       = skin_count_q;
    skin_count_valid_d = 1'b0;
    if (vld_p1_q) begin
      if (fe_p1_q) begin
        skin_count_d       = cnt_inc;
        skin_count_valid_d = 1'b1;
        frame_cnt_d        = '0;
      end else begin
        frame_cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q        <= '0;
      skin_count_q       <= '0;
      skin_count_valid_q <= 1'b0;
    end else begin
      frame_cnt_q        <= frame_cnt_d;
      skin_count_q       <= skin_count_d;
      skin_count_valid_q <= skin_count_valid_d;
    end
  end

  assign skin_count       = skin_count_q;
  assign skin_count_valid = skin_count_valid_q;
`else
  logic unused_cnt;
  assign unused_cnt       = fe_p1_q;
  assign skin_count       = '0;
  assign skin_count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_skin_classifier.sv
// Directed and random scoreboard bench for skin_classifier; expectations come
// from an integer model of the distance test and the per-frame counter.
module tb_skin_classifier;

  localparam int CR_DELAY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cr_value;
  logic        cr_value_valid;
  logic        frame_end;
  logic [17:0] mean_cr_result;
  logic        mean_cr_result_valid;
  logic        skin_mask;
  logic        skin_mask_valid;
  logic [19:0] skin_count;
  logic        skin_count_valid;
  logic        align_error;

  skin_classifier #(.CR_DELAY(CR_DELAY)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cr_value             (cr_value),
    .cr_value_valid       (cr_value_valid),
    .frame_end            (frame_end),
    .mean_cr_result       (mean_cr_result),
    .mean_cr_result_valid (mean_cr_result_valid),
    .skin_mask            (skin_mask),
    .skin_mask_valid      (skin_mask_valid),
    .skin_count           (skin_count),
    .skin_count_valid     (skin_count_valid),
    .align_error          (align_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit mask;
    bit has_cnt;
    int cnt;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  px_cr[$];
  logic [17:0] px_mean[$];
  bit          px_fe[$];
  int          model_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit model_mask(input int cr, input int mean);
    int m;
    int d;
    m = (mean == 0) ? 78848 : mean;
    d = cr * 512 - m;
    if (d < 0) d = -d;
    return d <= 5120;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cr_value = '0; cr_value_valid = 1'b0; frame_end = 1'b0;
    mean_cr_result = '0; mean_cr_result_valid = 1'b0;
  endtask

  task automatic push_px(input int cr, input int mean, input bit fe);
    px_cr.push_back(8'(cr));
    px_mean.push_back(18'(mean));
    px_fe.push_back(fe);
  endtask

  task automatic clear_px();
    px_cr.delete(); px_mean.delete(); px_fe.delete();
  endtask

  // Drives the queued pixels; the mean stream trails by CR_DELAY+lag cycles.
  task automatic run_stream(input int lag, input int abort_t);
    int   n;
    int   k;
    exp_t e;
    n = px_cr.size();
    for (int t = 0; t < n + CR_DELAY + lag + 1; t++) begin
      if (t == abort_t) break;
      k = t - CR_DELAY - lag;
      idle_inputs();
      if (t < n) begin
        cr_value = px_cr[t]; cr_value_valid = 1'b1; frame_end = px_fe[t];
      end
      if (k >= 0 && k < n) begin
        mean_cr_result = px_mean[k]; mean_cr_result_valid = 1'b1;
        if (lag == 0) begin
          e.mask = model_mask(int'(px_cr[k]), int'(px_mean[k]));
          if (e.mask && model_cnt < 1048575) model_cnt++;
          e.has_cnt = 1'b0;
          e.cnt = 0;
`ifdef SKIN_COUNT_EN
          if (px_fe[k]) begin
            e.has_cnt = 1'b1; e.cnt = model_cnt; model_cnt = 0;
          end
`endif
          e.cyc = cyc + 2;
          sb.push_back(e);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic drain(input string tag);
    repeat (4) step();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  exp_t got_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (skin_mask_valid) begin
        chk("unexpected_valid", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          chk("skin_mask", 32'(skin_mask), 32'(got_e.mask));
          chk("latency_cycle", 32'(cyc), 32'(got_e.cyc));
          chk("skin_count_valid", 32'(skin_count_valid), 32'(got_e.has_cnt));
          if (got_e.has_cnt) chk("skin_count", 32'(skin_count), 32'(got_e.cnt));
`ifndef SKIN_COUNT_EN
          chk("skin_count_tied", 32'(skin_count), 32'd0);
`endif
        end
      end else begin
        chk("count_valid_without_mask", 32'(skin_count_valid), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_skin_mask", 32'(skin_mask), 32'd0);
    chk("rst_skin_mask_valid", 32'(skin_mask_valid), 32'd0);
    chk("rst_skin_count", 32'(skin_count), 32'd0);
    chk("rst_skin_count_valid", 32'(skin_count_valid), 32'd0);
    chk("rst_align_error", 32'(align_error), 32'd0);
    step(); step();
    rst = 1'b0;
    step(); step();

    // Threshold boundaries, default-mean substitution, frame of 4 skin.
    clear_px();
    push_px(154, 78848, 0);
    push_px(165, 78848, 0);
    push_px(164, 78848, 0);
    push_px(143, 78848, 0);
    push_px(144, 78848, 0);
    push_px(150, 0, 0);
    push_px(200, 78848, 1);
    run_stream(0, -1);
    drain("drain_directed");

    // Six back-to-back pixels, four skin, frame_end on the sixth.
    clear_px();
    push_px(154, 78848, 0);
    push_px(160, 78848, 0);
    push_px(100, 78848, 0);
    push_px(164, 78848, 0);
    push_px(170, 78848, 0);
    push_px(148, 78848, 1);
    run_stream(0, -1);
    drain("drain_frame6");

    // Consecutive frame_end pixels, then a short frame; fractional means.
    clear_px();
    push_px(154, 78848, 1);
    push_px(154, 78848, 1);
    push_px(100, 78848, 0);
    push_px(164, 79104, 0);
    push_px(165, 79104, 1);
    run_stream(0, -1);
    drain("drain_consec");

    clear_px();
    for (int i = 0; i < 24; i++)
      push_px($urandom_range(120, 190),
              ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(140 * 512, 170 * 512),
              $urandom_range(0, 5) == 0);
    run_stream(0, -1);
    drain("drain_random");

    // Mean arrives one cycle late: alignment error, no output.
    clear_px();
    push_px(154, 78848, 0);
    run_stream(1, -1);
    drain("drain_misalign");
    chk("align_error_set", 32'(align_error), 32'd1);
    clear_px();
    push_px(154, 78848, 0);
    push_px(170, 78848, 0);
    run_stream(0, -1);
    drain("drain_after_misalign");
    chk("align_error_sticky", 32'(align_error), 32'd1);

    // Reset with three pixels in flight.
    clear_px();
    push_px(154, 78848, 0);
    push_px(154, 78848, 0);
    push_px(154, 78848, 1);
    run_stream(0, CR_DELAY + 1);
    #2;
    rst = 1'b1;
    #1;
    chk("inflight_rst_skin_mask", 32'(skin_mask), 32'd0);
    chk("inflight_rst_skin_mask_valid", 32'(skin_mask_valid), 32'd0);
    chk("inflight_rst_skin_count", 32'(skin_count), 32'd0);
    chk("inflight_rst_skin_count_valid", 32'(skin_count_valid), 32'd0);
    chk("inflight_rst_align_error", 32'(align_error), 32'd0);
    sb.delete();
    model_cnt = 0;
    step(); step();
    rst = 1'b0;
    repeat (12) step();
    chk("no_output_after_rst", 32'(sb.size()), 32'd0);

    clear_px();
    push_px(150, 78848, 0);
    push_px(164, 78848, 1);
    run_stream(0, -1);
    drain("drain_post_rst");
    chk("align_error_after_rst", 32'(align_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skin_classifier.md
SKIN_CLASSIFIER -- requirements
Module: skin_classifier

Interface
REQ-001 Parameter CR_DELAY, default 4: cycles from cr_value_valid to matching mean_cr_result_valid; range 1..8.
REQ-002 Parameter THRESH, default 18'd5120: skin distance limit in 9.9 fixed point (10.0).
REQ-003 Parameter MEAN_DEFAULT, default 18'd78848: substitute mean when mean_cr_result==0 (154.0 in 9.9).
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cr_value  input  8  pixel Cr sample, unsigned integer; accompanies y_value sent to the upstream mean stage.
REQ-007 cr_value_valid  input  1  qualifies cr_value and frame_end.
REQ-008 frame_end  input  1  marks last pixel of frame; sampled only with cr_value_valid.
REQ-009 mean_cr_result  input  18  mean Cr from upstream stage, unsigned 9.9.
REQ-010 mean_cr_result_valid  input  1  qualifies mean_cr_result.
REQ-011 skin_mask  output  1  1 = pixel classified skin.
REQ-012 skin_mask_valid  output  1  qualifies skin_mask, one pulse per pixel.
REQ-013 skin_count  output  20  skin pixels in last completed frame.
REQ-014 skin_count_valid  output  1  one-cycle pulse when skin_count updates.
REQ-015 align_error  output  1  sticky flag: delayed Cr and mean valid disagreed.

Function
REQ-016 Cr, cr_value_valid and frame_end SHALL pass through a CR_DELAY-stage shift register; valid bit shifts every cycle.
REQ-017 Pixel accepted when delayed valid and mean_cr_result_valid are both 1 in the same cycle.
REQ-018 Delayed valid XOR mean_cr_result_valid SHALL set align_error; no pixel emitted for that cycle.
REQ-019 Effective mean = MEAN_DEFAULT if mean_cr_result==0, else mean_cr_result.
REQ-020 Stage 1: diff = {1'b0, cr, 9'b0} - {1'b0, mean}, 19-bit two's complement, registered.
REQ-021 Stage 2: skin_mask = (|diff| <= THRESH), inclusive; |diff| 18 bits unsigned, never overflows.
REQ-022 skin_mask_valid asserts exactly 2 cycles after accepting mean_cr_result_valid; fully pipelined, one pixel per cycle, no stalls.
REQ-023 Skin counter increments on each skin_mask_valid with skin_mask=1; saturates at 20'hFFFFF.
REQ-024 When stage-2 pixel carries delayed frame_end: skin_count <= counter value including that pixel; skin_count_valid pulses same cycle as its skin_mask_valid; counter clears to 0.
REQ-025 Consecutive frame_end pixels SHALL each produce a pulse; second count covers only pixels since first.

Reset
REQ-026 rst clears delay line, pipeline valids, counter, skin_mask, skin_mask_valid, skin_count, skin_count_valid, align_error to 0 immediately.
REQ-027 Pixels in flight at reset are discarded; first valid output after release requires fresh input.
REQ-028 align_error clears only on rst.

Configuration
REQ-029 Macro SKIN_COUNT_EN defined: REQ-023..025 counter logic present.
REQ-030 SKIN_COUNT_EN undefined: no counter logic; skin_count tied 0, skin_count_valid tied 0; frame_end ignored; mask path unchanged.

Structure
REQ-031 Package skintone_pkg holds fixed-point width constants (integer 9, fraction 9), MEAN_DEFAULT value, count width 20.
REQ-032 Sub-module cr_delay_line implements REQ-016 (parameterised depth and data width); top instantiates it once.

Verification
REQ-033 cr=154, mean=154.0 aligned -> skin_mask=1, skin_mask_valid 2 cycles after mean valid.
REQ-034 cr=165 (diff 11.0) -> mask 0; cr=164 (diff 10.0) -> mask 1; cr=143 -> mask 0.
REQ-035 mean_cr_result=0, cr=150 -> uses 154.0, diff 4.0 -> mask 1.
REQ-036 Mean valid delivered 1 cycle late vs CR_DELAY -> align_error=1 and stays 1; no skin_mask_valid for those cycles.
REQ-037 Frame of 6 back-to-back pixels, 4 skin, frame_end on sixth -> skin_count=4, skin_count_valid pulse with sixth mask; next frame starts from 0.
REQ-038 rst asserted with 3 pixels in flight -> all outputs 0 same cycle, no outputs after release until new inputs.
